// File: rtl/addr_reg_bank_if.sv
// Control and read-back bundle for addr_reg_bank: load bus, register/function selects,
// two read selects and their registered data, plus the sticky wrap flags.
interface addr_reg_bank_if #(
    parameter int unsigned NUM_REGS = 3,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned IN_W     = 32
);
    localparam int unsigned SEL_W = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;

    logic [IN_W-1:0]     i;
    logic [NUM_REGS-1:0] reg_sel;
    logic [1:0]          fun_sel;
    logic [SEL_W-1:0]    out_c_sel;
    logic [SEL_W-1:0]    out_d_sel;
    logic [DATA_W-1:0]   out_c;
    logic [DATA_W-1:0]   out_d;
    logic [NUM_REGS-1:0] wrap;

    modport master (
        output i, reg_sel, fun_sel, out_c_sel, out_d_sel,
        input  out_c, out_d, wrap
    );

    modport slave (
        input  i, reg_sel, fun_sel, out_c_sel, out_d_sel,
        output out_c, out_d, wrap
    );
endinterface

// File: rtl/addr_reg_bank.sv
// Address register bank: NUM_REGS registers with load/clear/inc/dec, two registered read ports
// and sticky per-register wrap flags. Define ADDR_REG_BANK_SAT_EN for saturating inc/dec.
module addr_reg_bank #(
    parameter int unsigned NUM_REGS = 3,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned IN_W     = 32
) (
    input logic            clock_i,
    input logic            reset_i,
    addr_reg_bank_if.slave bus
);
    localparam int unsigned SEL_W = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;

`ifdef ADDR_REG_BANK_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             wrap_q, wrap_d;
    logic [DATA_W-1:0]               out_c_q, out_c_d;
    logic [DATA_W-1:0]               out_d_q, out_d_d;

    always_comb begin
        regs_d = regs_q;
        wrap_d = wrap_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.reg_sel[k]) begin
                unique case (bus.fun_sel)
                    2'b00: begin
                        if (regs_q[k] == '0) begin
                            wrap_d[k] = 1'b1;
                            regs_d[k] = SatEn ? regs_q[k] : '1;
                        end else begin
                            regs_d[k] = regs_q[k] - DATA_W'(1);
                        end
                    end
                    2'b01: begin
                        if (&regs_q[k]) begin
                            wrap_d[k] = 1'b1;
                            regs_d[k] = SatEn ? regs_q[k] : '0;
                        end else begin
                            regs_d[k] = regs_q[k] + DATA_W'(1);
                        end
                    end
                    2'b10: begin
                        regs_d[k] = bus.i[DATA_W-1:0];
                        wrap_d[k] = 1'b0;
                    end
                    2'b11: begin
                        regs_d[k] = '0;
                        wrap_d[k] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Out-of-range selects fall through to the last register.
    always_comb begin
        out_c_d = regs_q[NUM_REGS-1];
        out_d_d = regs_q[NUM_REGS-1];
        for (int k = 0; k < NUM_REGS - 1; k++) begin
            if (bus.out_c_sel == SEL_W'(k)) out_c_d = regs_q[k];
            if (bus.out_d_sel == SEL_W'(k)) out_d_d = regs_q[k];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            regs_q  <= '0;
            wrap_q  <= '0;
            out_c_q <= '0;
            out_d_q <= '0;
        end else begin
            regs_q  <= regs_d;
            wrap_q  <= wrap_d;
            out_c_q <= out_c_d;
            out_d_q <= out_d_d;
        end
    end

    assign bus.out_c = out_c_q;
    assign bus.out_d = out_d_q;
    assign bus.wrap  = wrap_q;

    if (IN_W > DATA_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^bus.i[IN_W-1:DATA_W];
    end
endmodule

// File: tb/tb_addr_reg_bank.sv
// Bench for addr_reg_bank: per-cycle compare against a behavioural model (default geometry)
// plus directed literal checks, and a second 5x24 instance for select clamping and wrap.
module tb_addr_reg_bank;
    localparam int NR  = 3;
    localparam int DW  = 16;
    localparam int NR2 = 5;
    localparam int DW2 = 24;
    localparam longint MAXV = (64'd1 << DW) - 1;

`ifdef ADDR_REG_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bit clk;
    logic rst;
    int errors = 0;
    int checks = 0;

    addr_reg_bank_if #(.NUM_REGS(NR),  .DATA_W(DW),  .IN_W(32)) bus  ();
    addr_reg_bank_if #(.NUM_REGS(NR2), .DATA_W(DW2), .IN_W(32)) bus2 ();

    addr_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .IN_W(32)) u_dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    addr_reg_bank #(.NUM_REGS(NR2), .DATA_W(DW2), .IN_W(32)) u_dut2 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the default instance.
    longint m_reg [NR] = '{default: 0};
    longint m_c = 0, m_d = 0;
    bit [NR-1:0] m_wrap = '0;

    function automatic int clamp(input int sel);
        return (sel >= NR) ? NR - 1 : sel;
    endfunction

    always @(posedge clk or posedge rst) begin
        longint nr [NR];
        bit [NR-1:0] nw;
        if (rst) begin
            m_reg  <= '{default: 0};
            m_wrap <= '0;
            m_c    <= 0;
            m_d    <= 0;
        end else begin
            nr = m_reg;
            nw = m_wrap;
            for (int k = 0; k < NR; k++) begin
                if (bus.reg_sel[k]) begin
                    case (bus.fun_sel)
                        2'b00: if (m_reg[k] == 0) begin
                            nw[k] = 1'b1;
                            nr[k] = SAT ? 0 : MAXV;
                        end else nr[k] = m_reg[k] - 1;
                        2'b01: if (m_reg[k] == MAXV) begin
                            nw[k] = 1'b1;
                            nr[k] = SAT ? MAXV : 0;
                        end else nr[k] = m_reg[k] + 1;
                        2'b10: begin nr[k] = longint'(bus.i) % (MAXV + 1); nw[k] = 1'b0; end
                        default: begin nr[k] = 0; nw[k] = 1'b0; end
                    endcase
                end
            end
            m_c    <= m_reg[clamp(int'(bus.out_c_sel))];
            m_d    <= m_reg[clamp(int'(bus.out_d_sel))];
            m_reg  <= nr;
            m_wrap <= nw;
        end
    end

    always @(negedge clk) begin
        check("cyc_out_c", longint'(bus.out_c), m_c);
        check("cyc_out_d", longint'(bus.out_d), m_d);
        check("cyc_wrap",  longint'(bus.wrap),  longint'(m_wrap));
    end

    // Apply one op to the default instance; returns 1ns after the edge that executes it.
    task automatic step(input logic [NR-1:0] rs, input logic [1:0] fs, input logic [31:0] d,
                        input logic [1:0] cs, input logic [1:0] ds);
        @(negedge clk);
        #1;
        bus.reg_sel = rs; bus.fun_sel = fs; bus.i = d; bus.out_c_sel = cs; bus.out_d_sel = ds;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [NR2-1:0] rs, input logic [1:0] fs, input logic [31:0] d,
                         input logic [2:0] cs);
        @(negedge clk);
        #1;
        bus.reg_sel = '0;
        bus2.reg_sel = rs; bus2.fun_sel = fs; bus2.i = d; bus2.out_c_sel = cs;
        bus2.out_d_sel = 3'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.reg_sel = '0; bus.fun_sel = '0; bus.i = '0; bus.out_c_sel = '0; bus.out_d_sel = '0;
        bus2.reg_sel = '0; bus2.fun_sel = '0; bus2.i = '0;
        bus2.out_c_sel = '0; bus2.out_d_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_c", longint'(bus.out_c), 0);
        check("rst_wrap", longint'(bus.wrap), 0);
        @(negedge clk);
        rst = 1'b0;

        // Load latency
        step(3'b001, 2'b10, 32'hABCD1234, 2'd0, 2'd0);
        check("lat_edge_n", longint'(bus.out_c), 0);
        step(3'b000, 2'b00, 32'h0, 2'd0, 2'd0);
        check("lat_edge_n1", longint'(bus.out_c), 64'h1234);

        // Multi-select increment; select 3 clamps to AR
        repeat (3) step(3'b110, 2'b01, 32'h0, 2'd1, 2'd3);
        step(3'b000, 2'b00, 32'h0, 2'd1, 2'd3);
        check("multi_sp", longint'(bus.out_c), 3);
        check("multi_ar_clamp", longint'(bus.out_d), 3);
        step(3'b000, 2'b00, 32'h0, 2'd0, 2'd2);
        check("multi_pc_held", longint'(bus.out_c), 64'h1234);

        // AR wrap at all-ones, sticky through decrement and reads, cleared by clear
        step(3'b100, 2'b10, 32'h5555FFFF, 2'd2, 2'd2);
        step(3'b100, 2'b01, 32'h0, 2'd2, 2'd2);
        check("wrap_set", longint'(bus.wrap), 64'b100);
        step(3'b000, 2'b00, 32'h0, 2'd2, 2'd2);
        check("wrap_inc_val", longint'(bus.out_c), SAT ? 64'hFFFF : 64'h0);
        step(3'b100, 2'b00, 32'h0, 2'd2, 2'd0);
        check("wrap_sticky", longint'(bus.wrap), 64'b100);
        step(3'b000, 2'b00, 32'h0, 2'd2, 2'd2);
        check("wrap_dec_val", longint'(bus.out_c), SAT ? 64'hFFFE : 64'hFFFF);
        step(3'b100, 2'b11, 32'h0, 2'd2, 2'd2);
        check("wrap_clear", longint'(bus.wrap), 0);

        // SP decrement from 0 and increment at all-ones
        step(3'b010, 2'b11, 32'h0, 2'd1, 2'd1);
        step(3'b010, 2'b00, 32'h0, 2'd1, 2'd1);
        step(3'b000, 2'b00, 32'h0, 2'd1, 2'd1);
        check("sp_dec0_val", longint'(bus.out_c), SAT ? 64'h0 : 64'hFFFF);
        check("sp_dec0_wrap", longint'(bus.wrap), 64'b010);
        step(3'b010, 2'b10, 32'h0000FFFF, 2'd1, 2'd1);
        check("sp_load_clears_wrap", longint'(bus.wrap), 0);
        step(3'b010, 2'b01, 32'h0, 2'd1, 2'd1);
        step(3'b000, 2'b00, 32'h0, 2'd1, 2'd0);
        check("sp_inc_max_val", longint'(bus.out_c), SAT ? 64'hFFFF : 64'h0);
        check("pc_port_d", longint'(bus.out_d), 64'h1234);

        // Asynchronous reset mid-cycle with registers nonzero
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_c", longint'(bus.out_c), 0);
        check("async_rst_out_d", longint'(bus.out_d), 0);
        check("async_rst_wrap", longint'(bus.wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        step(3'b000, 2'b00, 32'h0, 2'd0, 2'd0);
        step(3'b000, 2'b00, 32'h0, 2'd0, 2'd0);
        check("async_rst_pc", longint'(bus.out_c), 0);

        // 5 x 24 instance: select 7 reads reg 4, all-ones increment wraps
        step2(5'b10000, 2'b10, 32'hAAFFFFFF, 3'd7);
        step2(5'b10000, 2'b01, 32'h0, 3'd7);
        check("p2_clamp_pre", longint'(bus2.out_c), 64'hFFFFFF);
        check("p2_wrap", longint'(bus2.wrap), 64'b10000);
        step2(5'b00000, 2'b00, 32'h0, 3'd7);
        check("p2_inc_val", longint'(bus2.out_c), SAT ? 64'hFFFFFF : 64'h0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
